sys_ctrl_cmd_decoder: RTL and testbench
=======================================

// Module: sys_ctrl_cmd_decoder
// PURPOSE
//  Consumes the byte stream from the UART RX deserialiser and decodes host command frames.
//  Executes each frame against the register file and the ALU, and queues response bytes
//  into the TX FIFO. Sits between UART RX (upstream) and RegFile/ALU/TX FIFO (downstream)
//  in the REF_CLK domain. Gates the ALU clock off when the ALU is idle.
// PARAMETERS
//  DATA_WIDTH  8     byte width of RX/TX/RegFile data
//  ADDR_WIDTH  4     RegFile address width (taken from low bits of address byte)
//  ALU_OUT_W   16    ALU result width; sent as ALU_OUT_W/DATA_WIDTH bytes
//  CMD_WR      8'hAA RegFile write: CMD, ADDR, DATA
//  CMD_RD      8'hBB RegFile read:  CMD, ADDR
//  CMD_ALU_WP  8'hCC ALU with operands: CMD, A, B, FUN
//  CMD_ALU_NP  8'hDD ALU no operands:   CMD, FUN
// PORTS
//  CLK          in  1          system clock (REF_CLK domain)
//  RST          in  1          synchronous reset, active-high
//  RX_P_DATA    in  8          received byte
//  RX_D_VLD     in  1          1-cycle pulse, RX_P_DATA valid
//  RF_ADDRESS   out ADDR_WIDTH RegFile address
//  RF_WR_EN     out 1          RegFile write strobe, 1 cycle
//  RF_WR_DATA   out 8          RegFile write data
//  RF_RD_EN     out 1          RegFile read strobe, 1 cycle
//  RF_RD_DATA   in  8          RegFile read data
//  RF_RD_VLD    in  1          RF_RD_DATA valid
//  ALU_FUN      out 4          ALU function select
//  ALU_EN       out 1          ALU start, 1-cycle pulse
//  ALU_OUT      in  ALU_OUT_W  ALU result
//  ALU_OUT_VLD  in  1          ALU result valid
//  CLK_GATE_EN  out 1          ALU clock-gate enable
//  TX_P_DATA    out 8          response byte to TX FIFO
//  TX_D_VLD     out 1          TX FIFO push; never asserted while TX_FIFO_FULL=1
//  TX_FIFO_FULL in  1          TX FIFO full backpressure
//  CMD_ERR      out 1          1-cycle pulse: unknown command or byte dropped
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=IDLE; latched address/function cleared.
//  - States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, SEND.
//  - IDLE, RX_D_VLD: AA->WR_ADDR; BB->RD_ADDR; CC->ALU_A; DD->ALU_FUN;
//    any other byte -> CMD_ERR pulse next cycle, stay IDLE.
//  - WR: ADDR byte latched. On DATA byte: RF_WR_EN=1 next cycle with latched addr/data -> IDLE.
//  - RD: on ADDR byte: RF_RD_EN=1 next cycle -> RD_WAIT. RF_RD_VLD captures byte -> SEND (1 byte).
//  - ALU_WP: A byte -> RF write addr 0; B byte -> RF write addr 1 (strobe next cycle each).
//    -> ALU_FUN. CLK_GATE_EN rises on entry to ALU_FUN (NP path: right after DD).
//    FUN byte: ALU_FUN=byte[3:0] held, ALU_EN pulse next cycle -> ALU_WAIT.
//    ALU_OUT_VLD captures result, CLK_GATE_EN drops the next cycle -> SEND (2 bytes, LSB first).
//  - SEND: one byte pushed per cycle with TX_FIFO_FULL=0; stalls while full, no byte lost/repeated.
//    After last byte -> IDLE.
//  - RX_D_VLD in RD_WAIT/ALU_WAIT/SEND: byte dropped, CMD_ERR pulse, state unaffected.
//  - Mid-frame bytes are never decoded as commands (0xAA as DATA is data).
//  - Wait states have no timeout; RST is the only escape.
//  - RST mid-operation: abort frame next edge. No strobe or TX push after reset. CLK_GATE_EN=0.
//  - Latency: last frame byte -> RF strobe / ALU_EN is 1 cycle. Result valid -> first TX_D_VLD is 1 cycle if not full.
// STRUCTURE
//  - Package sys_ctrl_pkg: command code localparams, FSM state enum, ALU function codes.
//  - One sub-module: sys_ctrl_tx_sender. Loads 1 or 2 bytes, handles TX_FIFO_FULL stall,
//    returns done pulse.
// TESTING
//  1. Reset. Send AA,05,77 -> single RF_WR_EN pulse with RF_ADDRESS=5, RF_WR_DATA=0x77. No TX push.
//  2. Send BB,02; RF returns 0x5A with RF_RD_VLD -> RF_RD_EN with addr 2, then one TX push 0x5A.
//  3. Send CC,05,03,01 -> RF writes addr0=05, addr1=03; ALU_EN pulse with ALU_FUN=1.
//     CLK_GATE_EN high until ALU_OUT_VLD. ALU_OUT=0x0002 -> TX 0x02 then 0x00.
//  4. Send DD,00; ALU_OUT=0x0108; TX_FIFO_FULL=1 for 5 cycles -> no push while full,
//     then 0x08, 0x01 in order.
//  5. Send 3C -> CMD_ERR pulse, state IDLE. Send byte during ALU_WAIT -> CMD_ERR, result still sent.
//  6. RST after AA,05 -> next 0x77 gives CMD_ERR, no RF_WR_EN. Fresh AA frame then decodes correctly.

Source files
------------

// File: rtl/sys_ctrl_cmd_decoder_pkg.sv
// ---------------------------------------------------------------------------
// sys_ctrl_pkg
//   Shared definitions for the system-control command decoder:
//   host command codes, FSM state encoding, ALU function codes,
//   fixed RegFile slots for ALU operands and a byte-count helper.
// ---------------------------------------------------------------------------
package sys_ctrl_pkg;

  // Host command codes (first byte of every frame)
  localparam logic [7:0] CMD_WR_CODE     = 8'hAA;
  localparam logic [7:0] CMD_RD_CODE     = 8'hBB;
  localparam logic [7:0] CMD_ALU_WP_CODE = 8'hCC;
  localparam logic [7:0] CMD_ALU_NP_CODE = 8'hDD;

  // ALU function select
  localparam int ALU_FUN_W = 4;
  localparam logic [ALU_FUN_W-1:0] ALU_ADD = 4'h0;
  localparam logic [ALU_FUN_W-1:0] ALU_SUB = 4'h1;
  localparam logic [ALU_FUN_W-1:0] ALU_MUL = 4'h2;
  localparam logic [ALU_FUN_W-1:0] ALU_DIV = 4'h3;
  localparam logic [ALU_FUN_W-1:0] ALU_AND = 4'h4;
  localparam logic [ALU_FUN_W-1:0] ALU_OR  = 4'h5;
  localparam logic [ALU_FUN_W-1:0] ALU_XOR = 4'h6;
  localparam logic [ALU_FUN_W-1:0] ALU_CMP = 4'h7;

  // RegFile slots where the ALU picks up its operands
  localparam int ALU_OP_A_ADDR = 0;
  localparam int ALU_OP_B_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    ALU_A,
    ALU_B,
    ALU_FUN,
    ALU_WAIT,
    SEND
  } state_e;

  // Number of bytes needed to carry a value of width w in dw-bit bytes
  function automatic int bytes_for(input int w, input int dw);
    return (w + dw - 1) / dw;
  endfunction

endpackage

// File: rtl/sys_ctrl_cmd_decoder_if.sv
// ---------------------------------------------------------------------------
// sys_ctrl_cmd_decoder_if
//   Bundles every bus the decoder touches:
//     rx_*          byte stream from the UART RX deserialiser
//     rf_*          RegFile write/read port
//     alu_*         ALU start/function/result, clk_gate_en for the ALU clock
//     tx_*          push port into the TX FIFO with full backpressure
//     cmd_err       error pulse (unknown command / dropped byte)
//   modport master : decoder side
//   modport slave  : environment side (RX, RegFile, ALU, TX FIFO)
// ---------------------------------------------------------------------------
interface sys_ctrl_cmd_decoder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ALU_OUT_W  = 16
);
  import sys_ctrl_pkg::*;

  logic [DATA_WIDTH-1:0] rx_p_data;
  logic                  rx_d_vld;

  logic [ADDR_WIDTH-1:0] rf_address;
  logic                  rf_wr_en;
  logic [DATA_WIDTH-1:0] rf_wr_data;
  logic                  rf_rd_en;
  logic [DATA_WIDTH-1:0] rf_rd_data;
  logic                  rf_rd_vld;

  logic [ALU_FUN_W-1:0]  alu_fun;
  logic                  alu_en;
  logic [ALU_OUT_W-1:0]  alu_out;
  logic                  alu_out_vld;
  logic                  clk_gate_en;

  logic [DATA_WIDTH-1:0] tx_p_data;
  logic                  tx_d_vld;
  logic                  tx_fifo_full;

  logic                  cmd_err;

  modport master (
    input  rx_p_data, rx_d_vld,
    output rf_address, rf_wr_en, rf_wr_data, rf_rd_en,
    input  rf_rd_data, rf_rd_vld,
    output alu_fun, alu_en, clk_gate_en,
    input  alu_out, alu_out_vld,
    output tx_p_data, tx_d_vld,
    input  tx_fifo_full,
    output cmd_err
  );

  modport slave (
    output rx_p_data, rx_d_vld,
    input  rf_address, rf_wr_en, rf_wr_data, rf_rd_en,
    output rf_rd_data, rf_rd_vld,
    input  alu_fun, alu_en, clk_gate_en,
    output alu_out, alu_out_vld,
    input  tx_p_data, tx_d_vld,
    output tx_fifo_full,
    input  cmd_err
  );

endinterface

// File: rtl/sys_ctrl_cmd_decoder_tx_sender.sv
// ---------------------------------------------------------------------------
// sys_ctrl_tx_sender
//   Holds a 1..N byte response and pushes it into the TX FIFO LSB first,
//   one byte per cycle while the FIFO is not full.
//   Ports:
//     clk, rst       clock, synchronous active-high reset
//     load           capture load_data / load_bytes (only when idle)
//     load_data      response word, byte 0 in the low bits
//     load_bytes     number of bytes to send
//     tx_fifo_full   FIFO backpressure
//     tx_p_data      byte currently offered
//     tx_d_vld       FIFO push
//     done           1-cycle pulse on the push of the last byte
// ---------------------------------------------------------------------------
module sys_ctrl_tx_sender
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ALU_OUT_W  = 16,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ALU_OUT_W-1:0]  load_data,
  input  logic [CNT_W-1:0]      load_bytes,
  input  logic                  tx_fifo_full,
  output logic [DATA_WIDTH-1:0] tx_p_data,
  output logic                  tx_d_vld,
  output logic                  done
);

  logic [ALU_OUT_W-1:0] shreg;
  logic [CNT_W-1:0]     remaining;
  logic                 push;

  // Push is qualified with the live full flag so no byte is ever offered
  // to a full FIFO; the byte stays in shreg until it is accepted.
  assign push      = (remaining != '0) && !tx_fifo_full;
  assign tx_d_vld  = push;
  assign tx_p_data = shreg[DATA_WIDTH-1:0];
  assign done      = push && (remaining == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      remaining <= '0;
    end else if (load) begin
      shreg     <= load_data;
      remaining <= load_bytes;
    end else if (push) begin
      shreg     <= shreg >> DATA_WIDTH;
      remaining <= remaining - CNT_W'(1);
    end
  end

endmodule

// File: rtl/sys_ctrl_cmd_decoder.sv
// ---------------------------------------------------------------------------
// sys_ctrl_cmd_decoder
//   Decodes host command frames arriving byte by byte from UART RX,
//   executes them against the RegFile / ALU and queues the response bytes
//   into the TX FIFO. Gates the ALU clock on only while an ALU op is pending.
//   Frames:
//     AA addr data       RegFile write
//     BB addr            RegFile read, 1 response byte
//     CC a b fun         operands to RegFile[0]/[1], then ALU, result bytes
//     DD fun             ALU on current operands, result bytes
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     bus (master)       RX, RegFile, ALU, TX FIFO and cmd_err signals
// ---------------------------------------------------------------------------
module sys_ctrl_cmd_decoder
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ALU_OUT_W  = 16,
  parameter logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(CMD_WR_CODE),
  parameter logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(CMD_RD_CODE),
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_WP = DATA_WIDTH'(CMD_ALU_WP_CODE),
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_NP = DATA_WIDTH'(CMD_ALU_NP_CODE)
) (
  input logic clk,
  input logic rst,
  sys_ctrl_cmd_decoder_if.master bus
);

  localparam int TX_BYTES = bytes_for(ALU_OUT_W, DATA_WIDTH);
  localparam int CNT_W    = $clog2(TX_BYTES + 1);

  state_e                state;
  logic [ADDR_WIDTH-1:0] wr_addr;

  logic [ADDR_WIDTH-1:0] rf_address_q;
  logic                  rf_wr_en_q;
  logic [DATA_WIDTH-1:0] rf_wr_data_q;
  logic                  rf_rd_en_q;
  logic [ALU_FUN_W-1:0]  alu_fun_q;
  logic                  alu_en_q;
  logic                  clk_gate_en_q;
  logic                  cmd_err_q;

  logic                  send_load;
  logic [ALU_OUT_W-1:0]  send_data;
  logic [CNT_W-1:0]      send_bytes;
  logic                  send_done;

  // Response capture is combinational so the sender is loaded on the same
  // edge that sees the valid; the first push then appears one cycle later.
  always_comb begin
    send_load  = 1'b0;
    send_data  = '0;
    send_bytes = '0;
    if (state == RD_WAIT && bus.rf_rd_vld) begin
      send_load  = 1'b1;
      send_data  = ALU_OUT_W'(bus.rf_rd_data);
      send_bytes = CNT_W'(1);
    end else if (state == ALU_WAIT && bus.alu_out_vld) begin
      send_load  = 1'b1;
      send_data  = bus.alu_out;
      send_bytes = CNT_W'(TX_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wr_addr       <= '0;
      rf_address_q  <= '0;
      rf_wr_en_q    <= 1'b0;
      rf_wr_data_q  <= '0;
      rf_rd_en_q    <= 1'b0;
      alu_fun_q     <= '0;
      alu_en_q      <= 1'b0;
      clk_gate_en_q <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below
      rf_wr_en_q <= 1'b0;
      rf_rd_en_q <= 1'b0;
      alu_en_q   <= 1'b0;
      cmd_err_q  <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.rx_d_vld) begin
            if (bus.rx_p_data == CMD_WR) begin
              state <= WR_ADDR;
            end else if (bus.rx_p_data == CMD_RD) begin
              state <= RD_ADDR;
            end else if (bus.rx_p_data == CMD_ALU_WP) begin
              state <= ALU_A;
            end else if (bus.rx_p_data == CMD_ALU_NP) begin
              state         <= ALU_FUN;
              clk_gate_en_q <= 1'b1;
            end else begin
              cmd_err_q <= 1'b1;
            end
          end
        end

        WR_ADDR: begin
          if (bus.rx_d_vld) begin
            wr_addr <= bus.rx_p_data[ADDR_WIDTH-1:0];
            state   <= WR_DATA;
          end
        end

        WR_DATA: begin
          if (bus.rx_d_vld) begin
            rf_address_q <= wr_addr;
            rf_wr_data_q <= bus.rx_p_data;
            rf_wr_en_q   <= 1'b1;
            state        <= IDLE;
          end
        end

        RD_ADDR: begin
          if (bus.rx_d_vld) begin
            rf_address_q <= bus.rx_p_data[ADDR_WIDTH-1:0];
            rf_rd_en_q   <= 1'b1;
            state        <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (bus.rx_d_vld) cmd_err_q <= 1'b1;
          if (bus.rf_rd_vld) state <= SEND;
        end

        ALU_A: begin
          if (bus.rx_d_vld) begin
            rf_address_q <= ADDR_WIDTH'(ALU_OP_A_ADDR);
            rf_wr_data_q <= bus.rx_p_data;
            rf_wr_en_q   <= 1'b1;
            state        <= ALU_B;
          end
        end

        ALU_B: begin
          if (bus.rx_d_vld) begin
            rf_address_q  <= ADDR_WIDTH'(ALU_OP_B_ADDR);
            rf_wr_data_q  <= bus.rx_p_data;
            rf_wr_en_q    <= 1'b1;
            clk_gate_en_q <= 1'b1;
            state         <= ALU_FUN;
          end
        end

        ALU_FUN: begin
          if (bus.rx_d_vld) begin
            alu_fun_q <= bus.rx_p_data[ALU_FUN_W-1:0];
            alu_en_q  <= 1'b1;
            state     <= ALU_WAIT;
          end
        end

        ALU_WAIT: begin
          if (bus.rx_d_vld) cmd_err_q <= 1'b1;
          if (bus.alu_out_vld) begin
            clk_gate_en_q <= 1'b0;
            state         <= SEND;
          end
        end

        SEND: begin
          if (bus.rx_d_vld) cmd_err_q <= 1'b1;
          if (send_done) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rf_address  = rf_address_q;
  assign bus.rf_wr_en    = rf_wr_en_q;
  assign bus.rf_wr_data  = rf_wr_data_q;
  assign bus.rf_rd_en    = rf_rd_en_q;
  assign bus.alu_fun     = alu_fun_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.clk_gate_en = clk_gate_en_q;
  assign bus.cmd_err     = cmd_err_q;

  sys_ctrl_tx_sender #(
    .DATA_WIDTH (DATA_WIDTH),
    .ALU_OUT_W  (ALU_OUT_W),
    .CNT_W      (CNT_W)
  ) u_tx_sender (
    .clk          (clk),
    .rst          (rst),
    .load         (send_load),
    .load_data    (send_data),
    .load_bytes   (send_bytes),
    .tx_fifo_full (bus.tx_fifo_full),
    .tx_p_data    (bus.tx_p_data),
    .tx_d_vld     (bus.tx_d_vld),
    .done         (send_done)
  );

endmodule

// File: tb/tb_sys_ctrl_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_sys_ctrl_cmd_decoder
//   Drives host frames into sys_ctrl_cmd_decoder and plays the RegFile,
//   ALU and TX FIFO. Expected RegFile writes/reads, ALU functions and TX
//   bytes are queued when a frame is sent and checked as the DUT emits them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sys_ctrl_cmd_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sys_ctrl_cmd_decoder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_OUT_W(16)) bus ();

  sys_ctrl_cmd_decoder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_OUT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [11:0] exp_wr[$];
  logic [3:0]  exp_rd[$];
  logic [3:0]  exp_fun[$];
  logic [7:0]  exp_tx[$];

  int wr_seen = 0, rd_seen = 0, alu_en_seen = 0, tx_seen = 0, err_seen = 0;

  logic [11:0] w_exp;
  logic [3:0]  a_exp, f_exp;
  logic [7:0]  t_exp;

  // Scoreboard monitor: every strobe / push the DUT makes is popped
  // against the queue filled when the stimulus was driven.
  always @(negedge clk) begin
    if (bus.rf_wr_en === 1'b1) begin
      wr_seen++;
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL rf_write_unexpected: got addr=%h data=%h, required no write",
                 bus.rf_address, bus.rf_wr_data);
      end else begin
        w_exp = exp_wr.pop_front();
        if ({bus.rf_address, bus.rf_wr_data} !== w_exp) begin
          errors++;
          $display("FAIL rf_write: got addr=%h data=%h, required addr=%h data=%h",
                   bus.rf_address, bus.rf_wr_data, w_exp[11:8], w_exp[7:0]);
        end
      end
    end
    if (bus.rf_rd_en === 1'b1) begin
      rd_seen++;
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL rf_read_unexpected: got addr=%h, required no read", bus.rf_address);
      end else begin
        a_exp = exp_rd.pop_front();
        if (bus.rf_address !== a_exp) begin
          errors++;
          $display("FAIL rf_read_addr: got %h, required %h", bus.rf_address, a_exp);
        end
      end
    end
    if (bus.alu_en === 1'b1) begin
      alu_en_seen++;
      checks++;
      if (exp_fun.size() == 0) begin
        errors++;
        $display("FAIL alu_en_unexpected: got fun=%h, required no ALU start", bus.alu_fun);
      end else begin
        f_exp = exp_fun.pop_front();
        if (bus.alu_fun !== f_exp) begin
          errors++;
          $display("FAIL alu_fun: got %h, required %h", bus.alu_fun, f_exp);
        end
      end
    end
    if (bus.tx_d_vld === 1'b1) begin
      tx_seen++;
      checks++;
      if (bus.tx_fifo_full !== 1'b0) begin
        errors++;
        $display("FAIL tx_push_while_full: got push with full=%b, required no push",
                 bus.tx_fifo_full);
      end
      checks++;
      if (exp_tx.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got byte %h, required no push", bus.tx_p_data);
      end else begin
        t_exp = exp_tx.pop_front();
        if (bus.tx_p_data !== t_exp) begin
          errors++;
          $display("FAIL tx_byte: got %h, required %h", bus.tx_p_data, t_exp);
        end
      end
    end
    if (bus.cmd_err === 1'b1) err_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_p_data = b;
    bus.rx_d_vld  = 1'b1;
    tick();
    bus.rx_d_vld  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({bus.rf_wr_en, bus.rf_rd_en, bus.alu_en, bus.clk_gate_en, bus.tx_d_vld, bus.cmd_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got wr/rd/alu/gate/tx/err=%b, required 000000",
               {bus.rf_wr_en, bus.rf_rd_en, bus.alu_en, bus.clk_gate_en, bus.tx_d_vld, bus.cmd_err});
    end
    checks++;
    if ({bus.rf_address, bus.rf_wr_data, bus.alu_fun, bus.tx_p_data} !== 28'h0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h fun=%h tx=%h, required all 0",
               bus.rf_address, bus.rf_wr_data, bus.alu_fun, bus.tx_p_data);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    int wr0 = wr_seen, tx0 = tx_seen;
    exp_wr.push_back({4'h5, 8'h77});
    send_byte(8'hAA);
    send_byte(8'h05);
    send_byte(8'h77);
    @(negedge clk);
    checks++;
    if (!(bus.rf_wr_en === 1'b1 && bus.rf_address === 4'h5 && bus.rf_wr_data === 8'h77)) begin
      errors++;
      $display("FAIL write_latency: got en=%b addr=%h data=%h, required en=1 addr=5 data=77",
               bus.rf_wr_en, bus.rf_address, bus.rf_wr_data);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.rf_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL write_pulse_width: got en=%b second cycle, required 0", bus.rf_wr_en);
    end
    repeat (3) tick();
    checks++;
    if (wr_seen - wr0 != 1 || tx_seen != tx0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL write_counts: got writes=%0d tx=%0d pending=%0d, required 1 0 0",
               wr_seen - wr0, tx_seen - tx0, exp_wr.size());
    end
  endtask

  task automatic test_read();
    int tx0 = tx_seen;
    exp_rd.push_back(4'h2);
    exp_tx.push_back(8'h5A);
    send_byte(8'hBB);
    send_byte(8'h02);
    @(negedge clk);
    checks++;
    if (!(bus.rf_rd_en === 1'b1 && bus.rf_address === 4'h2)) begin
      errors++;
      $display("FAIL read_strobe: got en=%b addr=%h, required en=1 addr=2",
               bus.rf_rd_en, bus.rf_address);
    end
    tick();
    bus.rf_rd_data = 8'h5A;
    bus.rf_rd_vld  = 1'b1;
    tick();
    bus.rf_rd_vld  = 1'b0;
    @(negedge clk);
    checks++;
    if (!(bus.tx_d_vld === 1'b1 && bus.tx_p_data === 8'h5A)) begin
      errors++;
      $display("FAIL read_tx_latency: got vld=%b byte=%h, required vld=1 byte=5a",
               bus.tx_d_vld, bus.tx_p_data);
    end
    repeat (3) tick();
    checks++;
    if (tx_seen - tx0 != 1 || exp_tx.size() != 0 || exp_rd.size() != 0) begin
      errors++;
      $display("FAIL read_counts: got tx=%0d pending_tx=%0d pending_rd=%0d, required 1 0 0",
               tx_seen - tx0, exp_tx.size(), exp_rd.size());
    end
  endtask

  task automatic test_alu_wp();
    int tx0 = tx_seen;
    exp_wr.push_back({4'h0, 8'h05});
    exp_wr.push_back({4'h1, 8'h03});
    exp_fun.push_back(4'h1);
    exp_tx.push_back(8'h02);
    exp_tx.push_back(8'h00);
    send_byte(8'hCC);
    send_byte(8'h05);
    send_byte(8'h03);
    @(negedge clk);
    checks++;
    if (bus.clk_gate_en !== 1'b1) begin
      errors++;
      $display("FAIL alu_gate_rise: got %b after B byte, required 1", bus.clk_gate_en);
    end
    tick();
    send_byte(8'h01);
    @(negedge clk);
    checks++;
    if (!(bus.alu_en === 1'b1 && bus.alu_fun === 4'h1)) begin
      errors++;
      $display("FAIL alu_start: got en=%b fun=%h, required en=1 fun=1", bus.alu_en, bus.alu_fun);
    end
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (!(bus.clk_gate_en === 1'b1 && bus.alu_en === 1'b0 && bus.alu_fun === 4'h1)) begin
      errors++;
      $display("FAIL alu_wait_hold: got gate=%b en=%b fun=%h, required 1 0 1",
               bus.clk_gate_en, bus.alu_en, bus.alu_fun);
    end
    tick();
    bus.alu_out     = 16'h0002;
    bus.alu_out_vld = 1'b1;
    tick();
    bus.alu_out_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (!(bus.tx_d_vld === 1'b1 && bus.tx_p_data === 8'h02 && bus.clk_gate_en === 1'b0)) begin
      errors++;
      $display("FAIL alu_result: got vld=%b byte=%h gate=%b, required 1 02 0",
               bus.tx_d_vld, bus.tx_p_data, bus.clk_gate_en);
    end
    repeat (3) tick();
    checks++;
    if (tx_seen - tx0 != 2 || exp_tx.size() != 0 || exp_wr.size() != 0 || exp_fun.size() != 0) begin
      errors++;
      $display("FAIL alu_wp_counts: got tx=%0d pending tx/wr/fun=%0d/%0d/%0d, required 2 0/0/0",
               tx_seen - tx0, exp_tx.size(), exp_wr.size(), exp_fun.size());
    end
  endtask

  task automatic test_alu_np_full();
    int tx0 = tx_seen;
    exp_fun.push_back(4'h0);
    exp_tx.push_back(8'h08);
    exp_tx.push_back(8'h01);
    send_byte(8'hDD);
    @(negedge clk);
    checks++;
    if (bus.clk_gate_en !== 1'b1) begin
      errors++;
      $display("FAIL np_gate_rise: got %b after DD, required 1", bus.clk_gate_en);
    end
    tick();
    send_byte(8'h00);
    tick();
    bus.tx_fifo_full = 1'b1;
    bus.alu_out      = 16'h0108;
    bus.alu_out_vld  = 1'b1;
    tick();
    bus.alu_out_vld  = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (tx_seen != tx0 || bus.tx_d_vld !== 1'b0) begin
      errors++;
      $display("FAIL np_stall: got pushes=%0d vld=%b while full, required 0 0",
               tx_seen - tx0, bus.tx_d_vld);
    end
    tick();
    bus.tx_fifo_full = 1'b0;
    @(negedge clk);
    checks++;
    if (!(bus.tx_d_vld === 1'b1 && bus.tx_p_data === 8'h08)) begin
      errors++;
      $display("FAIL np_first_byte: got vld=%b byte=%h, required 1 08", bus.tx_d_vld, bus.tx_p_data);
    end
    tick();
    bus.tx_fifo_full = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.tx_d_vld !== 1'b0) begin
      errors++;
      $display("FAIL np_mid_stall: got vld=%b while full, required 0", bus.tx_d_vld);
    end
    tick();
    bus.tx_fifo_full = 1'b0;
    @(negedge clk);
    checks++;
    if (!(bus.tx_d_vld === 1'b1 && bus.tx_p_data === 8'h01)) begin
      errors++;
      $display("FAIL np_second_byte: got vld=%b byte=%h, required 1 01", bus.tx_d_vld, bus.tx_p_data);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.tx_d_vld !== 1'b0 || tx_seen - tx0 != 2 || exp_tx.size() != 0) begin
      errors++;
      $display("FAIL np_done: got vld=%b pushes=%0d pending=%0d, required 0 2 0",
               bus.tx_d_vld, tx_seen - tx0, exp_tx.size());
    end
    tick();
  endtask

  task automatic test_cmd_err();
    int e0 = err_seen, tx0 = tx_seen;
    send_byte(8'h3C);
    @(negedge clk);
    checks++;
    if (bus.cmd_err !== 1'b1) begin
      errors++;
      $display("FAIL err_unknown_cmd: got cmd_err=%b, required 1", bus.cmd_err);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse_width: got cmd_err=%b second cycle, required 0", bus.cmd_err);
    end
    exp_fun.push_back(4'h2);
    exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h12);
    tick();
    send_byte(8'hDD);
    send_byte(8'h02);
    tick();
    send_byte(8'h55);
    @(negedge clk);
    checks++;
    if (!(bus.cmd_err === 1'b1 && bus.alu_en === 1'b0 && bus.clk_gate_en === 1'b1)) begin
      errors++;
      $display("FAIL err_in_wait: got err=%b alu_en=%b gate=%b, required 1 0 1",
               bus.cmd_err, bus.alu_en, bus.clk_gate_en);
    end
    tick();
    bus.alu_out     = 16'h1234;
    bus.alu_out_vld = 1'b1;
    tick();
    bus.alu_out_vld = 1'b0;
    repeat (4) tick();
    checks++;
    if (err_seen - e0 != 2 || tx_seen - tx0 != 2 || exp_tx.size() != 0 || exp_fun.size() != 0) begin
      errors++;
      $display("FAIL err_counts: got errs=%0d tx=%0d pending tx/fun=%0d/%0d, required 2 2 0/0",
               err_seen - e0, tx_seen - tx0, exp_tx.size(), exp_fun.size());
    end
  endtask

  task automatic test_reset_abort();
    int wr0 = wr_seen;
    send_byte(8'hAA);
    send_byte(8'h05);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send_byte(8'h77);
    @(negedge clk);
    checks++;
    if (!(bus.cmd_err === 1'b1 && bus.rf_wr_en === 1'b0)) begin
      errors++;
      $display("FAIL abort_then_77: got err=%b wr_en=%b, required 1 0", bus.cmd_err, bus.rf_wr_en);
    end
    exp_wr.push_back({4'hA, 8'hAA});
    tick();
    send_byte(8'hAA);
    send_byte(8'h0A);
    send_byte(8'hAA);
    @(negedge clk);
    checks++;
    if (!(bus.rf_wr_en === 1'b1 && bus.rf_address === 4'hA && bus.rf_wr_data === 8'hAA)) begin
      errors++;
      $display("FAIL fresh_write: got en=%b addr=%h data=%h, required 1 a aa",
               bus.rf_wr_en, bus.rf_address, bus.rf_wr_data);
    end
    tick();
    send_byte(8'hDD);
    @(negedge clk);
    checks++;
    if (bus.clk_gate_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_gate_pre: got %b, required 1", bus.clk_gate_en);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.clk_gate_en !== 1'b0 || wr_seen - wr0 != 1 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL abort_gate_post: got gate=%b writes=%0d pending=%0d, required 0 1 0",
               bus.clk_gate_en, wr_seen - wr0, exp_wr.size());
    end
    repeat (3) tick();
  endtask

  initial begin
    bus.rx_p_data    = '0;
    bus.rx_d_vld     = 1'b0;
    bus.rf_rd_data   = '0;
    bus.rf_rd_vld    = 1'b0;
    bus.alu_out      = '0;
    bus.alu_out_vld  = 1'b0;
    bus.tx_fifo_full = 1'b0;

    test_reset();
    test_write();
    test_read();
    test_alu_wp();
    test_alu_np_full();
    test_cmd_err();
    test_reset_abort();

    checks++;
    if (exp_wr.size() + exp_rd.size() + exp_fun.size() + exp_tx.size() != 0) begin
      errors++;
      $display("FAIL final_queues: got %0d expected events never seen, required 0",
               exp_wr.size() + exp_rd.size() + exp_fun.size() + exp_tx.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
